// File: rtl/dep_check_unit_pkg.sv
// Shared definitions for the decode-stage dependency checker.
//   - opcode constants for the three opcodes the checker decodes specially
//   - operand-source select encodings driven to the register bank muxes
//   - stage_tag_t: per-stage record of destination register, write flag, load flag
//   - tag_hit(): one tag versus one source-register comparison
package dep_check_unit_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LD  = 5'h14;
    localparam logic [4:0] OP_ST  = 5'h15;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_DM = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b11;

    typedef struct packed {
        logic [4:0] rd;
        logic       writes;
        logic       is_load;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '{rd: 5'd0, writes: 1'b0, is_load: 1'b0};

    // r0 is an ordinary register: a hit only needs a writing producer and equal addresses.
    function automatic logic tag_hit(input stage_tag_t tag, input logic [4:0] src);
        return tag.writes && (tag.rd == src);
    endfunction

endpackage

// File: rtl/dep_check_unit_dep_cmp.sv
// dep_cmp: compares one source-register field against the EX, DM and WB tags
// and returns a priority-encoded operand select (youngest producer wins).
//   src    : source register address from decode
//   ex_tag : tag of the instruction in EX
//   dm_tag : tag of the instruction in DM
//   wb_tag : tag of the instruction in WB
//   sel    : SEL_EX / SEL_DM / SEL_WB / SEL_RF
// Build option: FWD_WB_EN enables the WB-stage forward (SEL_WB). Without it
// the register bank is write-before-read, so a WB-only hit reads the regfile.
module dep_cmp
    import dep_check_unit_pkg::*;
(
    input  logic [4:0] src,
    input  stage_tag_t ex_tag,
    input  stage_tag_t dm_tag,
    input  stage_tag_t wb_tag,
    output logic [1:0] sel
);

    // Load flags (and the WB tag in the default build) are not needed for the select.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{ex_tag.is_load, dm_tag.is_load, wb_tag};

    // Priority select: EX, then DM, then (optionally) WB, else register file.
    always_comb begin
        sel = SEL_RF;
        if (tag_hit(ex_tag, src)) begin
            sel = SEL_EX;
        end else if (tag_hit(dm_tag, src)) begin
            sel = SEL_DM;
`ifdef FWD_WB_EN
        end else if (tag_hit(wb_tag, src)) begin
            sel = SEL_WB;
`endif
        end else begin
            sel = SEL_RF;
        end
    end

endmodule

// File: rtl/dep_check_unit.sv
// dep_check_unit: decode-stage hazard detection and forwarding-select unit.
// Tracks the EX/DM/WB destination tags and, for the instruction in decode,
// chooses operand sources and requests a one-cycle load-use stall.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   ins        : decode instruction {opcode[19:15], rd[14:10], rs1[9:5], rs2[4:0]}
//   mux_sel_A  : operand-A source (00 rf, 01 EX, 10 DM, 11 WB)
//   mux_sel_B  : operand-B source, forced 00 when imm_sel=1
//   imm_sel    : operand B is the immediate (ins[19])
//   stall      : hold decode, inject a bubble into EX
//   RW_dm      : destination register of the DM-stage instruction
//   we_dm      : DM-stage instruction writes RW_dm
// Build option: FWD_WB_EN enables WB-stage forwarding (select 11).
module dep_check_unit
    import dep_check_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ins,
    output logic [1:0]  mux_sel_A,
    output logic [1:0]  mux_sel_B,
    output logic        imm_sel,
    output logic        stall,
    output logic [4:0]  RW_dm,
    output logic        we_dm
);

    stage_tag_t ex_r, dm_r, wb_r;
    stage_tag_t dec_tag_s;
    logic [4:0] opcode_s, rs1_s, rs2_s;
    logic [1:0] sel_a_s, sel_b_s;
    logic       imm_s, stall_s;

    assign opcode_s = ins[19:15];
    assign rs1_s    = ins[9:5];
    assign rs2_s    = ins[4:0];

    // Decode the incoming instruction into the tag it will carry down the pipe.
    always_comb begin
        dec_tag_s.rd      = ins[14:10];
        dec_tag_s.is_load = (opcode_s == OP_LD);
        if ((opcode_s == OP_NOP) || (opcode_s == OP_ST)) begin
            dec_tag_s.writes = 1'b0;
        end else begin
            dec_tag_s.writes = 1'b1;
        end
    end

    dep_cmp u_cmp_a (
        .src    (rs1_s),
        .ex_tag (ex_r),
        .dm_tag (dm_r),
        .wb_tag (wb_r),
        .sel    (sel_a_s)
    );

    dep_cmp u_cmp_b (
        .src    (rs2_s),
        .ex_tag (ex_r),
        .dm_tag (dm_r),
        .wb_tag (wb_r),
        .sel    (sel_b_s)
    );

    // Immediate class and load-use detection; imm_sel is held low during reset.
    always_comb begin
        if (reset) begin
            imm_s = ins[19];
        end else begin
            imm_s = 1'b0;
        end
        if (ex_r.is_load && ex_r.writes &&
            ((ex_r.rd == rs1_s) || ((ex_r.rd == rs2_s) && !imm_s))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Output selects: no forwarding while stalled; operand B ignores hits for immediates.
    always_comb begin
        if (stall_s) begin
            mux_sel_A = SEL_RF;
            mux_sel_B = SEL_RF;
        end else if (imm_s) begin
            mux_sel_A = sel_a_s;
            mux_sel_B = SEL_RF;
        end else begin
            mux_sel_A = sel_a_s;
            mux_sel_B = sel_b_s;
        end
    end

    assign imm_sel = imm_s;
    assign stall   = stall_s;

    // DM tag is itself a register, so these are registered views of it.
    assign RW_dm = dm_r.rd;
    assign we_dm = dm_r.writes;

    // Stage-tag pipeline; a stall replaces the EX entry with a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r <= TAG_BUBBLE;
            dm_r <= TAG_BUBBLE;
            wb_r <= TAG_BUBBLE;
        end else begin
            wb_r <= dm_r;
            dm_r <= ex_r;
            if (stall_s) begin
                ex_r <= TAG_BUBBLE;
            end else begin
                ex_r <= dec_tag_s;
            end
        end
    end

endmodule

// File: tb/tb_dep_check_unit.sv
module tb_dep_check_unit;

    logic        clk;
    logic        reset;
    logic [19:0] ins;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic        imm_sel, stall, we_dm;
    logic [4:0]  RW_dm;

    localparam logic [4:0] NOP  = 5'h00;
    localparam logic [4:0] ADD  = 5'h01;
    localparam logic [4:0] ADDI = 5'h10;
    localparam logic [4:0] LD   = 5'h14;
    localparam logic [4:0] ST   = 5'h15;
`ifdef FWD_WB_EN
    localparam logic [1:0] WB_SEL = 2'b11;
`else
    localparam logic [1:0] WB_SEL = 2'b00;
`endif

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       imm;
        logic       st;
        logic [4:0] rw;
        logic       we;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    dep_check_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ins       (ins),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
        .stall     (stall),
        .RW_dm     (RW_dm),
        .we_dm     (we_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic imm, input logic st, input logic [4:0] rw, input logic we);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.imm = imm; e.st = st; e.rw = rw; e.we = we;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".mux_sel_A"}, {6'd0, mux_sel_A}, {6'd0, e.a});
            cmp({e.tag, ".mux_sel_B"}, {6'd0, mux_sel_B}, {6'd0, e.b});
            cmp({e.tag, ".imm_sel"},   {7'd0, imm_sel},   {7'd0, e.imm});
            cmp({e.tag, ".stall"},     {7'd0, stall},     {7'd0, e.st});
            cmp({e.tag, ".RW_dm"},     {3'd0, RW_dm},     {3'd0, e.rw});
            cmp({e.tag, ".we_dm"},     {7'd0, we_dm},     {7'd0, e.we});
        end
    endtask

    // Drive one decode instruction just after a rising edge, check at the falling edge.
    task automatic step(input string tag, input logic [19:0] i, input logic [1:0] a,
                        input logic [1:0] b, input logic imm, input logic st,
                        input logic [4:0] rw, input logic we);
        @(posedge clk);
        #1;
        ins = i;
        push(tag, a, b, imm, st, rw, we);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        reset = 1'b0;
        ins   = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        // Immediate-class instruction whose sources hit r5 while reset is held.
        ins = mk(ADDI, 5'd5, 5'd5, 5'd5);
        push("rst_hold", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check_out();
        @(negedge clk);
        ins   = mk(NOP, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;

        step("rst_nop0", mk(NOP, 5'd0, 5'd0, 5'd0), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("rst_nop1", mk(NOP, 5'd0, 5'd0, 5'd0), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("rst_nop2", mk(NOP, 5'd0, 5'd0, 5'd0), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);

        // EX forward
        step("add_r5",   mk(ADD, 5'd5,  5'd20, 5'd21), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("ex_fwd",   mk(ADD, 5'd9,  5'd5,  5'd22), 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("dm_r5",    mk(NOP, 5'd0,  5'd0,  5'd0),  2'b00, 2'b00, 1'b0, 1'b0, 5'd5, 1'b1);

        // DM forward on operand B
        step("add_r6",   mk(ADD, 5'd6,  5'd20, 5'd21), 2'b00, 2'b00, 1'b0, 1'b0, 5'd9, 1'b1);
        step("nop_a",    mk(NOP, 5'd0,  5'd0,  5'd0),  2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("dm_fwd",   mk(ADD, 5'd10, 5'd22, 5'd6),  2'b00, 2'b10, 1'b0, 1'b0, 5'd6, 1'b1);

        // WB-only match on operand B
        step("add_r6b",  mk(ADD, 5'd6,  5'd20, 5'd21), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        step("nop_b",    mk(NOP, 5'd0,  5'd0,  5'd0),  2'b00, 2'b00, 1'b0, 1'b0, 5'd10, 1'b1);
        step("nop_c",    mk(NOP, 5'd0,  5'd0,  5'd0),  2'b00, 2'b00, 1'b0, 1'b0, 5'd6, 1'b1);
        step("wb_fwd",   mk(ADD, 5'd11, 5'd22, 5'd6),  2'b00, WB_SEL, 1'b0, 1'b0, 5'd0, 1'b0);

        // Load-use: one stall cycle, then DM forward with the same instruction held
        step("ld_r7",    mk(LD,  5'd7,  5'd20, 5'd21), 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
        step("ld_stall", mk(ADD, 5'd12, 5'd7,  5'd22), 2'b00, 2'b00, 1'b0, 1'b1, 5'd11, 1'b1);
        step("ld_fwd",   mk(ADD, 5'd12, 5'd7,  5'd22), 2'b10, 2'b00, 1'b0, 1'b0, 5'd7, 1'b1);

        // Store produces nothing; immediate suppresses operand-B forwarding
        step("st_r3",    mk(ST,  5'd3,  5'd20, 5'd21), 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
        step("st_nofwd", mk(ADD, 5'd13, 5'd3,  5'd22), 2'b00, 2'b00, 1'b0, 1'b0, 5'd12, 1'b1);
        step("imm_b",    mk(ADDI,5'd14, 5'd22, 5'd13), 2'b00, 2'b00, 1'b1, 1'b0, 5'd3, 1'b0);

        // Priority: youngest producer (EX) wins over DM
        step("add_r4a",  mk(ADD, 5'd4,  5'd20, 5'd21), 2'b00, 2'b00, 1'b0, 1'b0, 5'd13, 1'b1);
        step("add_r4b",  mk(ADD, 5'd4,  5'd20, 5'd21), 2'b00, 2'b00, 1'b0, 1'b0, 5'd14, 1'b1);
        step("prio",     mk(ADD, 5'd15, 5'd4,  5'd4),  2'b01, 2'b01, 1'b0, 1'b0, 5'd4, 1'b1);

        // Reset asserted mid-stall
        step("ld_r16",   mk(LD,  5'd16, 5'd20, 5'd21), 2'b00, 2'b00, 1'b1, 1'b0, 5'd4, 1'b1);
        step("stall2",   mk(ADD, 5'd17, 5'd16, 5'd22), 2'b00, 2'b00, 1'b0, 1'b1, 5'd15, 1'b1);
        #1;
        reset = 1'b0;
        push("rst_mid", 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        check_out();
        #1;
        reset = 1'b1;
        step("post_rst", mk(ADD, 5'd17, 5'd16, 5'd22), 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
